gb_cpu_sequencer: RTL and testbench

GB_CPU_SEQUENCER -- requirements
Module: gb_cpu_sequencer

---
 rtl/gb_cpu_common_pkg.sv | 74 +++++++
 rtl/gb_cpu_step_counter.sv | 41 ++++
 rtl/gb_cpu_sequencer.sv | 108 ++++++++++
 tb/tb_gb_cpu_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared sequencer state, control bundle and fixed control words
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    ADDR_PC = 2'd0,
    ADDR_SP = 2'd1,
    ADDR_HL = 2'd2,
    ADDR_WZ = 2'd3
  } addr_sel_t;

  typedef enum logic [1:0] {
    IDU_NOP = 2'd0,
    IDU_INC = 2'd1,
    IDU_DEC = 2'd2
  } idu_op_t;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_ADC = 3'd2,
    ALU_SUB = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_t;

  typedef struct packed {
    addr_sel_t addr_sel;
    logic      addr_drive;
    logic      data_to_ir;
    idu_op_t   idu_op;
    logic      idu_wren;
    alu_op_t   alu_op;
    logic      alu_wren;
    logic      rf_wren;
    logic      mem_wren;
    logic      pc_wren;
  } control_signals_t;

  // Opcode fetch: PC on the bus, byte into IR, IDU writes PC+1 back.
  localparam control_signals_t FETCH_CTRL = '{
    addr_sel:   ADDR_PC,
    addr_drive: 1'b1,
    data_to_ir: 1'b1,
    idu_op:     IDU_INC,
    idu_wren:   1'b1,
    alu_op:     ALU_NOP,
    alu_wren:   1'b0,
    rf_wren:    1'b0,
    mem_wren:   1'b0,
    pc_wren:    1'b0
  };

  localparam control_signals_t NOP_CTRL = '{
    addr_sel:   ADDR_PC,
    addr_drive: 1'b0,
    data_to_ir: 1'b0,
    idu_op:     IDU_NOP,
    idu_wren:   1'b0,
    alu_op:     ALU_NOP,
    alu_wren:   1'b0,
    rf_wren:    1'b0,
    mem_wren:   1'b0,
    pc_wren:    1'b0
  };

endpackage

// File: rtl/gb_cpu_step_counter.sv
// rtl/gb_cpu_step_counter.sv - execute step index and remaining-cycle counter pair
module gb_cpu_step_counter #(
  parameter int CYCLE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_hold,
  input  logic               i_load,
  input  logic [CYCLE_W-1:0] i_count,
  input  logic               i_advance,
  input  logic               i_clear,
  output logic [CYCLE_W-1:0] o_step,
  output logic               o_last
);

  logic [CYCLE_W-1:0] r_step;
  logic [CYCLE_W-1:0] r_remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step      <= '0;
      r_remaining <= '0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_step      <= '0;
        r_remaining <= i_count;
      end else if (i_advance) begin
        r_step      <= r_step + CYCLE_W'(1);
        r_remaining <= r_remaining - CYCLE_W'(1);
      end else if (i_clear) begin
        r_step      <= '0;
        r_remaining <= '0;
      end
    end
  end

  // Treating zero as last keeps a corrupted count from ever wrapping.
  assign o_step = r_step;
  assign o_last = (r_remaining <= CYCLE_W'(1));

endmodule

// File: rtl/gb_cpu_sequencer.sv
// rtl/gb_cpu_sequencer.sv - FETCH/EXEC/HALT M-cycle sequencer with CB-prefix and ISR tracking
module gb_cpu_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter int CYCLE_W   = 3,
  parameter int MAX_STEPS = 6,
  parameter int HALT_EN   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [CYCLE_W-1:0] sched_m_cycles,
  input  control_signals_t   sched_controls [MAX_STEPS],
  input  logic               sched_cb_prefix,
  input  logic               cond_fail,
  input  logic               irq_dispatch,
  input  logic               irq_wake,
  input  logic               halt_req,
  output control_signals_t   control_next,
  output logic [CYCLE_W-1:0] step,
  output logic               fetching,
  output logic               cb_prefix_o,
  output logic               isr_cmd,
  output logic               halted,
  output logic               sched_err
);

  localparam logic [CYCLE_W-1:0] MAX_STEPS_W = CYCLE_W'(MAX_STEPS);

  seq_state_t         r_state;
  logic               r_cb;
  logic               r_isr;
  logic               r_sched_err;

  logic               w_in_fetch;
  logic               w_in_exec;
  logic               w_in_halt;
  logic               w_over;
  logic [CYCLE_W-1:0] w_count;
  logic               w_start;
  logic               w_last;
  logic               w_complete;
  logic               w_halt_go;
  logic [CYCLE_W-1:0] w_step;

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_exec  = (r_state == ST_EXEC);
  assign w_in_halt  = (r_state == ST_HALT);
  assign w_over     = (sched_m_cycles > MAX_STEPS_W);
  assign w_count    = w_over ? MAX_STEPS_W : sched_m_cycles;
  assign w_start    = w_in_fetch && (sched_m_cycles != '0);
  assign w_complete = (w_in_fetch && (sched_m_cycles == '0)) ||
                      (w_in_exec && (cond_fail || w_last));
  assign w_halt_go  = (HALT_EN != 0) && halt_req && !irq_wake;

  gb_cpu_step_counter #(
    .CYCLE_W (CYCLE_W)
  ) u_step_counter (
    .clk       (clk),
    .reset     (reset),
    .i_hold    (stall),
    .i_load    (w_start),
    .i_count   (w_count),
    .i_advance (w_in_exec && !w_complete),
    .i_clear   (w_in_exec && w_complete),
    .o_step    (w_step),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_FETCH;
      r_cb        <= 1'b0;
      r_isr       <= 1'b0;
      r_sched_err <= 1'b0;
    end else if (!stall) begin
      r_sched_err <= w_start && w_over;
      if (w_complete) begin
        r_state <= w_halt_go ? ST_HALT : ST_FETCH;
        // A completing 0xCB opcode defers any interrupt until its body completes.
        r_cb    <= sched_cb_prefix && !r_cb;
        r_isr   <= !r_isr && irq_dispatch && !sched_cb_prefix;
      end else if (w_start) begin
        r_state <= ST_EXEC;
      end else if (w_in_halt && irq_wake) begin
        r_state <= ST_FETCH;
        r_isr   <= irq_dispatch;
      end
    end
  end

  always_comb begin
    control_next = NOP_CTRL;
    case (r_state)
      ST_FETCH: control_next = FETCH_CTRL;
      ST_EXEC:  if (w_step < MAX_STEPS_W) control_next = sched_controls[w_step];
      default:  control_next = NOP_CTRL;
    endcase
  end

  assign step        = w_step;
  assign fetching    = w_in_fetch;
  assign halted      = w_in_halt;
  assign cb_prefix_o = r_cb;
  assign isr_cmd     = r_isr;
  assign sched_err   = r_sched_err;

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// tb/tb_gb_cpu_sequencer.sv - directed self-checking bench for gb_cpu_sequencer
module tb_gb_cpu_sequencer;
  import gb_cpu_common_pkg::*;

  logic             clk;
  logic             reset;
  logic             stall;
  logic [2:0]       sched_m_cycles;
  control_signals_t sched_ctrl [6];
  logic             sched_cb_prefix;
  logic             cond_fail;
  logic             irq_dispatch;
  logic             irq_wake;
  logic             halt_req;
  control_signals_t control_next;
  logic [2:0]       step;
  logic             fetching;
  logic             cb_prefix_o;
  logic             isr_cmd;
  logic             halted;
  logic             sched_err;

  int checks = 0;
  int errors = 0;
  control_signals_t exp_fetch;
  control_signals_t exp_nop;

  gb_cpu_sequencer #(.CYCLE_W(3), .MAX_STEPS(6), .HALT_EN(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .sched_m_cycles  (sched_m_cycles),
    .sched_controls  (sched_ctrl),
    .sched_cb_prefix (sched_cb_prefix),
    .cond_fail       (cond_fail),
    .irq_dispatch    (irq_dispatch),
    .irq_wake        (irq_wake),
    .halt_req        (halt_req),
    .control_next    (control_next),
    .step            (step),
    .fetching        (fetching),
    .cb_prefix_o     (cb_prefix_o),
    .isr_cmd         (isr_cmd),
    .halted          (halted),
    .sched_err       (sched_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic control_signals_t mk_step(input int k);
    control_signals_t c;
    c = '0;
    c.addr_sel   = ADDR_HL;
    c.addr_drive = 1'b1;
    c.alu_op     = alu_op_t'(3'(k + 1));
    c.alu_wren   = 1'b1;
    c.rf_wren    = k[0];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_fetch            = '0;
    exp_fetch.addr_sel   = ADDR_PC;
    exp_fetch.addr_drive = 1'b1;
    exp_fetch.data_to_ir = 1'b1;
    exp_fetch.idu_op     = IDU_INC;
    exp_fetch.idu_wren   = 1'b1;
    exp_nop              = '0;
    for (int i = 0; i < 6; i++) sched_ctrl[i] = mk_step(i);

    reset = 1'b1; stall = 1'b0; sched_m_cycles = 3'd0; sched_cb_prefix = 1'b0;
    cond_fail = 1'b0; irq_dispatch = 1'b0; irq_wake = 1'b0; halt_req = 1'b0;
    tick();
    tick();
    chk("rst_fetching", 32'(fetching), 32'd1);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_cb", 32'(cb_prefix_o), 32'd0);
    chk("rst_isr", 32'(isr_cmd), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(sched_err), 32'd0);
    chk("rst_ctrl", 32'(control_next), 32'(exp_fetch));
    reset = 1'b0;

    // Back-to-back single-cycle opcodes
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("n0_fetching", 32'(fetching), 32'd1);
      chk("n0_ctrl", 32'(control_next), 32'(exp_fetch));
    end

    // N=3 with two stall cycles at step 1
    sched_m_cycles = 3'd3;
    tick();
    sched_m_cycles = 3'd0;
    chk("n3_s0_step", 32'(step), 32'd0);
    chk("n3_s0_fetching", 32'(fetching), 32'd0);
    chk("n3_s0_ctrl", 32'(control_next), 32'(mk_step(0)));
    tick();
    chk("n3_s1_step", 32'(step), 32'd1);
    chk("n3_s1_ctrl", 32'(control_next), 32'(mk_step(1)));
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_step", 32'(step), 32'd1);
      chk("stall_ctrl", 32'(control_next), 32'(mk_step(1)));
    end
    stall = 1'b0;
    tick();
    chk("n3_s2_step", 32'(step), 32'd2);
    chk("n3_s2_ctrl", 32'(control_next), 32'(mk_step(2)));
    tick();
    chk("n3_done_fetching", 32'(fetching), 32'd1);
    chk("n3_done_ctrl", 32'(control_next), 32'(exp_fetch));

    // N=5 abandoned by cond_fail at step 1
    sched_m_cycles = 3'd5;
    tick();
    sched_m_cycles = 3'd0;
    chk("cf_s0_step", 32'(step), 32'd0);
    tick();
    chk("cf_s1_step", 32'(step), 32'd1);
    cond_fail = 1'b1;
    tick();
    cond_fail = 1'b0;
    chk("cf_fetching", 32'(fetching), 32'd1);
    chk("cf_step", 32'(step), 32'd0);
    tick();
    chk("cf_stay_fetching", 32'(fetching), 32'd1);
    chk("cf_stay_step", 32'(step), 32'd0);

    // CB prefix followed by a one-cycle body with interrupt pending
    sched_cb_prefix = 1'b1;
    tick();
    sched_cb_prefix = 1'b0;
    sched_m_cycles  = 3'd1;
    irq_dispatch    = 1'b1;
    chk("cb1_cb", 32'(cb_prefix_o), 32'd1);
    chk("cb1_isr", 32'(isr_cmd), 32'd0);
    chk("cb1_fetching", 32'(fetching), 32'd1);
    tick();
    sched_m_cycles = 3'd0;
    chk("cb2_cb", 32'(cb_prefix_o), 32'd1);
    chk("cb2_isr", 32'(isr_cmd), 32'd0);
    chk("cb2_fetching", 32'(fetching), 32'd0);
    tick();
    irq_dispatch = 1'b0;
    chk("cb3_cb", 32'(cb_prefix_o), 32'd0);
    chk("cb3_isr", 32'(isr_cmd), 32'd1);
    tick();
    chk("isr_done", 32'(isr_cmd), 32'd0);

    // HALT for four cycles, woken without dispatch
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_ctrl", 32'(control_next), 32'(exp_nop));
      if (i < 3) tick();
    end
    irq_wake = 1'b1;
    tick();
    irq_wake = 1'b0;
    chk("wake_halted", 32'(halted), 32'd0);
    chk("wake_fetching", 32'(fetching), 32'd1);
    chk("wake_isr", 32'(isr_cmd), 32'd0);

    // Oversized schedule clamps to six steps and flags once
    sched_m_cycles = 3'd7;
    tick();
    sched_m_cycles = 3'd0;
    chk("ovr_err", 32'(sched_err), 32'd1);
    chk("ovr_s0_step", 32'(step), 32'd0);
    for (int k = 1; k < 6; k++) begin
      tick();
      chk("ovr_step", 32'(step), 32'(k));
      chk("ovr_exec", 32'(fetching), 32'd0);
      chk("ovr_err_low", 32'(sched_err), 32'd0);
    end
    tick();
    chk("ovr_done_fetching", 32'(fetching), 32'd1);
    chk("ovr_done_err", 32'(sched_err), 32'd0);

    // Reset (with stall asserted) in the middle of a CB-prefixed body
    sched_cb_prefix = 1'b1;
    tick();
    sched_cb_prefix = 1'b0;
    sched_m_cycles  = 3'd4;
    tick();
    sched_m_cycles = 3'd0;
    tick();
    tick();
    chk("pre_rst_step", 32'(step), 32'd2);
    chk("pre_rst_cb", 32'(cb_prefix_o), 32'd1);
    reset = 1'b1;
    stall = 1'b1;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    chk("mid_rst_fetching", 32'(fetching), 32'd1);
    chk("mid_rst_step", 32'(step), 32'd0);
    chk("mid_rst_cb", 32'(cb_prefix_o), 32'd0);
    chk("mid_rst_isr", 32'(isr_cmd), 32'd0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    chk("mid_rst_err", 32'(sched_err), 32'd0);
    chk("mid_rst_ctrl", 32'(control_next), 32'(exp_fetch));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
